// File: rtl/nx_stream_arbiter.sv
// N-to-1 stream arbiter feeding a small output FIFO.
// The grant is combinational against the current FIFO space, so a stream is never stalled by a registered ready.

package nx_stream_pkg;
    typedef logic [7:0] node_message_t;
    typedef enum logic [1:0] {
        DIRECTION_NORTH = 2'd0,
        DIRECTION_EAST  = 2'd1,
        DIRECTION_SOUTH = 2'd2,
        DIRECTION_WEST  = 2'd3
    } direction_t;
endpackage

module nx_stream_arbiter
    import nx_stream_pkg::*;
#(
    parameter int    INPUTS     = 4,
    parameter int    DEPTH      = 2,
    parameter string ARB_SCHEME = "round_robin"
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  node_message_t [INPUTS-1:0]     in_data_i,
    input  direction_t    [INPUTS-1:0]     in_dir_i,
    input  logic          [INPUTS-1:0]     in_valid_i,
    output logic          [INPUTS-1:0]     in_ready_o,
    output node_message_t                  comb_data_o,
    output direction_t                     comb_dir_o,
    output logic                           comb_valid_o,
    input  logic                           comb_ready_i,
    output logic                           idle_o
);

    localparam int IW = $clog2(INPUTS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SCHEME = (ARB_SCHEME == "prefer_low")  ? 1 :
                            (ARB_SCHEME == "prefer_high") ? 2 : 0;

    if (ARB_SCHEME != "round_robin" && ARB_SCHEME != "prefer_low" &&
        ARB_SCHEME != "prefer_high") begin : g_bad_scheme
        $error("nx_stream_arbiter: unknown ARB_SCHEME %s", ARB_SCHEME);
    end
    if (INPUTS < 2 || INPUTS > 8) begin : g_bad_inputs
        $error("nx_stream_arbiter: INPUTS must be 2..8");
    end
    if (DEPTH != 2 && DEPTH != 4 && DEPTH != 8) begin : g_bad_depth
        $error("nx_stream_arbiter: DEPTH must be 2, 4 or 8");
    end

    node_message_t mem_data [DEPTH];
    direction_t    mem_dir  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [IW-1:0] last_grant;

    logic          pop;
    logic          space;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] cand;

    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= INPUTS) sum = sum - INPUTS;
        return IW'(sum);
    endfunction

    // Outputs are forced quiet while reset is held, since count only clears at the edge.
    assign comb_valid_o = rst_i && (count != '0);
    assign comb_data_o  = comb_valid_o ? mem_data[rd_ptr] : '0;
    assign comb_dir_o   = comb_valid_o ? mem_dir[rd_ptr]  : DIRECTION_NORTH;
    assign idle_o       = (!rst_i || (count == '0)) && (in_valid_i == '0);

    assign pop   = comb_valid_o && comb_ready_i;
    assign space = (count < CW'(DEPTH)) || pop;

    // Loops run so that the winning candidate is the last one written.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (rst_i && space) begin
            if (SCHEME == 1) begin
                for (int i = INPUTS - 1; i >= 0; i--) begin
                    if (in_valid_i[i]) begin
                        grant_valid = 1'b1;
                        grant_idx   = IW'(i);
                    end
                end
            end else if (SCHEME == 2) begin
                for (int i = 0; i < INPUTS; i++) begin
                    if (in_valid_i[i]) begin
                        grant_valid = 1'b1;
                        grant_idx   = IW'(i);
                    end
                end
            end else begin
                for (int k = INPUTS; k >= 1; k--) begin
                    cand = rr_index(last_grant, k);
                    if (in_valid_i[cand]) begin
                        grant_valid = 1'b1;
                        grant_idx   = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready_o = '0;
        if (grant_valid) in_ready_o[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= IW'(INPUTS - 1);
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_dir[i]  <= DIRECTION_NORTH;
            end
        end else begin
            if (grant_valid) begin
                mem_data[wr_ptr] <= in_data_i[grant_idx];
                mem_dir[wr_ptr]  <= in_dir_i[grant_idx];
                wr_ptr           <= wr_ptr + PW'(1);
                last_grant       <= grant_idx;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({grant_valid, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Scoreboard bench for nx_stream_arbiter: a round-robin and a prefer_high instance share stimulus,
// a reference model predicts grants and FIFO contents for whichever instance is being observed.

module tb_nx_stream_arbiter;
    import nx_stream_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    node_message_t [N-1:0] in_data;
    direction_t    [N-1:0] in_dir;
    logic          [N-1:0] in_valid;
    logic                  comb_ready;

    logic [N-1:0]  rr_ready, ph_ready;
    node_message_t rr_data, ph_data;
    direction_t    rr_dir, ph_dir;
    logic          rr_valid, ph_valid, rr_idle, ph_idle;

    nx_stream_arbiter #(.INPUTS(N), .DEPTH(2), .ARB_SCHEME("round_robin")) dut_rr (
        .clk_i(clk), .rst_i(rst_n),
        .in_data_i(in_data), .in_dir_i(in_dir), .in_valid_i(in_valid), .in_ready_o(rr_ready),
        .comb_data_o(rr_data), .comb_dir_o(rr_dir), .comb_valid_o(rr_valid),
        .comb_ready_i(comb_ready), .idle_o(rr_idle)
    );

    nx_stream_arbiter #(.INPUTS(N), .DEPTH(2), .ARB_SCHEME("prefer_high")) dut_ph (
        .clk_i(clk), .rst_i(rst_n),
        .in_data_i(in_data), .in_dir_i(in_dir), .in_valid_i(in_valid), .in_ready_o(ph_ready),
        .comb_data_o(ph_data), .comb_dir_o(ph_dir), .comb_valid_o(ph_valid),
        .comb_ready_i(comb_ready), .idle_o(ph_idle)
    );

    bit            use_ph = 1'b0;
    logic [N-1:0]  obs_ready;
    node_message_t obs_data;
    direction_t    obs_dir;
    logic          obs_valid, obs_idle;

    always_comb begin
        obs_ready = use_ph ? ph_ready : rr_ready;
        obs_data  = use_ph ? ph_data  : rr_data;
        obs_dir   = use_ph ? ph_dir   : rr_dir;
        obs_valid = use_ph ? ph_valid : rr_valid;
        obs_idle  = use_ph ? ph_idle  : rr_idle;
    end

    int         num_checks = 0;
    int         num_fail   = 0;
    logic [9:0] exp_q[$];
    int         m_last = N - 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge: drive, predict, compare, then advance the model across the rising edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic [N-1:0] valid,
                                 input logic ready, input bit use_a5 = 1'b0);
        int          g;
        bit          exp_valid, pop, space;
        logic [N-1:0] exp_ready;
        logic [7:0]  exp_data;
        logic [1:0]  exp_dir;
        rst_n      = rst;
        in_valid   = valid;
        comb_ready = ready;
        for (int i = 0; i < N; i++) begin
            in_data[i] = node_message_t'($urandom_range(0, 255));
            in_dir[i]  = direction_t'($urandom_range(0, 3));
        end
        if (use_a5) in_data[0] = 8'hA5;
        #1;
        g         = -1;
        exp_valid = rst && (exp_q.size() != 0);
        pop       = exp_valid && ready;
        space     = (exp_q.size() < 2) || pop;
        if (rst && space) begin
            if (use_ph) begin
                for (int i = 0; i < N; i++) if (valid[i]) g = i;
            end else begin
                for (int k = N; k >= 1; k--) if (valid[(m_last + k) % N]) g = (m_last + k) % N;
            end
        end
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
        exp_data  = exp_valid ? exp_q[0][7:0] : 8'h00;
        exp_dir   = exp_valid ? exp_q[0][9:8] : 2'd0;
        checkOutput({tag, "_ready"}, 32'(obs_ready), 32'(exp_ready));
        checkOutput({tag, "_valid"}, 32'(obs_valid), 32'(exp_valid));
        checkOutput({tag, "_data"},  32'(obs_data),  32'(exp_data));
        checkOutput({tag, "_dir"},   32'(obs_dir),   32'(exp_dir));
        checkOutput({tag, "_idle"},  32'(obs_idle),
                    32'((!rst || exp_q.size() == 0) && valid == '0));
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            m_last = N - 1;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (g >= 0) begin
                exp_q.push_back({2'(in_dir[g]), in_data[g]});
                m_last = g;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        in_valid   = '0;
        comb_ready = 1'b0;
        in_data    = '0;
        in_dir     = {N{DIRECTION_NORTH}};
        @(negedge clk);
        applyStimulus("rst0", 1'b0, 3'b000, 1'b0);
        applyStimulus("rst1", 1'b0, 3'b010, 1'b1);
        applyStimulus("rst2", 1'b0, 3'b000, 1'b0);

        for (int c = 0; c < 7; c++) applyStimulus("all3", 1'b1, 3'b111, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus("drain", 1'b1, 3'b000, 1'b1);

        for (int c = 0; c < 4; c++) applyStimulus("fill1", 1'b1, 3'b010, 1'b0);
        for (int c = 0; c < 2; c++) applyStimulus("full_pp", 1'b1, 3'b010, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus("drain", 1'b1, 3'b000, 1'b1);

        applyStimulus("a5_push", 1'b1, 3'b001, 1'b1, 1'b1);
        checkOutput("a5_head_valid", 32'(obs_valid), 32'd1);
        checkOutput("a5_head_data", 32'(obs_data), 32'hA5);
        applyStimulus("a5_pop", 1'b1, 3'b000, 1'b1);
        applyStimulus("a5_empty", 1'b1, 3'b000, 1'b1);

        applyStimulus("pre_rst", 1'b1, 3'b111, 1'b0);
        applyStimulus("pre_rst", 1'b1, 3'b111, 1'b0);
        applyStimulus("mid_rst", 1'b0, 3'b000, 1'b0);
        applyStimulus("post_rst", 1'b1, 3'b101, 1'b0);
        applyStimulus("post_rst", 1'b1, 3'b101, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus("drain", 1'b1, 3'b000, 1'b1);
        applyStimulus("idle_wake", 1'b1, 3'b100, 1'b0);
        for (int c = 0; c < 2; c++) applyStimulus("drain", 1'b1, 3'b000, 1'b1);

        for (int c = 0; c < 30; c++)
            applyStimulus("rand", 1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

        use_ph = 1'b1;
        applyStimulus("ph_rst", 1'b0, 3'b000, 1'b0);
        for (int c = 0; c < 4; c++) applyStimulus("ph_hi", 1'b1, 3'b101, 1'b1);
        for (int c = 0; c < 12; c++)
            applyStimulus("ph_rand", 1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        for (int c = 0; c < 3; c++) applyStimulus("ph_drain", 1'b1, 3'b000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule

// File: doc/nx_stream_arbiter.md
NX_STREAM_ARBITER -- requirements
Module: nx_stream_arbiter

Interface
REQ-001 SHALL have parameter INPUTS, default 4: number of inbound streams; legal range 2..8.
REQ-002 SHALL have parameter DEPTH, default 2: output buffer entries; legal values 2, 4, 8.
REQ-003 SHALL have parameter ARB_SCHEME, default "round_robin": one of "round_robin", "prefer_low" or "prefer_high".
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_data_i, input, INPUTS x node_message_t: inbound messages.
REQ-007 SHALL have port in_dir_i, input, INPUTS x direction_t: inbound message directions.
REQ-008 SHALL have port in_valid_i, input, INPUTS bits: per-stream valid.
REQ-009 SHALL have port in_ready_o, output, INPUTS bits: per-stream ready.
REQ-010 SHALL have port comb_data_o, output, node_message_t: head-of-buffer message.
REQ-011 SHALL have port comb_dir_o, output, direction_t: head-of-buffer direction.
REQ-012 SHALL have port comb_valid_o, output, 1 bit: buffer non-empty.
REQ-013 SHALL have port comb_ready_i, input, 1 bit: downstream accepts the head.
REQ-014 SHALL have port idle_o, output, 1 bit: buffer empty and no in_valid_i bit set.

Function
REQ-015 SHALL hold a DEPTH-entry FIFO of {message, direction}, with read/write pointers that wrap modulo DEPTH and an occupancy count of width clog2(DEPTH)+1.
REQ-016 SHALL drive comb_valid_o = (count != 0), with comb_data_o/comb_dir_o taken from the head entry; these outputs SHALL be zero/DIRECTION_NORTH when the buffer is empty.
REQ-017 SHALL pop the head when comb_valid_o && comb_ready_i.
REQ-018 SHALL have space when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-019 SHALL grant at most one input per cycle, and only when space exists.
REQ-020 SHALL drive in_ready_o[i] high only for the granted index, combinationally; all other bits SHALL be low.
REQ-021 SHALL push in_data_i/in_dir_i of the granted index into the FIFO tail on a grant.
REQ-022 SHALL make a message accepted in cycle N visible on comb_*_o in cycle N+1 if the buffer was empty; the minimum latency is one cycle.
REQ-023 SHALL allow simultaneous push and pop, leaving count unchanged, including when the buffer is full and when count == 1.
REQ-024 SHALL, under "round_robin", search for the grant starting at (last_grant + 1) mod INPUTS, ascending with wrap; last_grant SHALL update only on an actual grant.
REQ-025 SHALL, under "prefer_low", grant the lowest-index valid input; under "prefer_high", it SHALL grant the highest-index valid input.
REQ-026 SHALL NOT require an upstream valid that is not granted to be held stable; an upstream valid that is not granted SHALL remain legal on the next cycle.
REQ-027 SHALL deassert all in_ready_o bits when the buffer is full and no pop occurs.
REQ-028 SHALL treat an invalid ARB_SCHEME as a compile-time error.
REQ-029 SHALL drive idle_o = (count == 0) && (in_valid_i == 0).

Reset
REQ-030 SHALL, while rst_i is low at a clock edge, clear count, pointers and FIFO contents, and set last_grant to INPUTS-1 so that the first round-robin search starts at index 0.
REQ-031 SHALL hold comb_valid_o = 0 and in_ready_o = 0 during reset, with idle_o reflecting in_valid_i only.
REQ-032 SHALL, on reset asserted mid-operation, discard buffered messages, and SHALL NOT emit them after release.

Verification (INPUTS=3, DEPTH=2, round_robin unless stated)
REQ-033 SHALL cover: inputs 0, 1 and 2 all valid continuously with comb_ready_i=1 -> grants 0,1,2,0,1,2; output carries one message per cycle starting one cycle after the first grant.
REQ-034 SHALL cover: input 1 alone valid with comb_ready_i=0 -> two grants; count=2; in_ready_o=000 thereafter; raising comb_ready_i -> pop and push in the same cycle, count stays 2.
REQ-035 SHALL cover: prefer_high, inputs 0 and 2 valid for 4 cycles -> input 2 granted every cycle; input 0 never granted.
REQ-036 SHALL cover: push msg 0xA5 from input 0 into an empty buffer with comb_ready_i=1 -> comb_valid_o=1 with data 0xA5 the next cycle; count returns to 0 one cycle later if there is no further input.
REQ-037 SHALL cover: buffer holding 2 entries, rst_i driven low for one edge -> comb_valid_o=0 and count=0; after release, input 2 and input 0 both valid -> input 0 granted first.
REQ-038 SHALL cover: all in_valid_i low and buffer drained -> idle_o=1; any in_valid_i high -> idle_o=0 in the same cycle.
